// File: rtl/movz_movk_sequencer.sv
// movz_movk_sequencer: turns a 64-bit constant plus a destination register
// into the shortest LEGv8 MOVZ/MOVK stream that rebuilds it, one 32-bit
// instruction per valid/ready transfer.
module movz_movk_sequencer #(
    parameter bit         SKIP_ZERO = 1'b1,
    parameter logic [8:0] MOVZ_OPC  = 9'b110100101,
    parameter logic [8:0] MOVK_OPC  = 9'b111100101
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_value,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] value_q, value_d;
    logic [4:0]  rd_q, rd_d;
    logic [3:0]  mask_q, mask_d;       // halfwords still to emit after the current one
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        out_last_q, out_last_d;

    logic [3:0]  accept_mask;
    logic [3:0]  src_mask;
    logic [1:0]  cur_idx;
    logic [3:0]  rem_mask;

    // Index of the lowest set bit; the mask is never empty when used.
    function automatic logic [1:0] lowest_idx(input logic [3:0] m);
        logic [1:0] r;
        r = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (m[3 - i]) r = 2'(3 - i);
        end
        return r;
    endfunction

    function automatic logic [15:0] halfword(input logic [63:0] v, input logic [1:0] idx);
        return v[{idx, 4'b0000} +: 16];
    endfunction

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_last  = out_last_q;

    // Pending-halfword mask for a new request, forced to hw0 for a zero constant.
    always_comb begin
        accept_mask = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            accept_mask[i] = (in_value[16*i +: 16] != 16'h0000);
        end
        if (!SKIP_ZERO) accept_mask = 4'b1111;
        if (accept_mask == 4'b0000) accept_mask = 4'b0001;
    end

    // Next-state and next-instruction computation.
    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        rd_d        = rd_q;
        mask_d      = mask_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_last_d  = out_last_q;

        src_mask = (state_q == IDLE) ? accept_mask : mask_q;
        cur_idx  = lowest_idx(src_mask);
        rem_mask = src_mask & ~(4'b0001 << cur_idx);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d     = EMIT;
                    value_d     = in_value;
                    rd_d        = in_rd;
                    mask_d      = rem_mask;
                    out_valid_d = 1'b1;
                    out_instr_d = {MOVZ_OPC, cur_idx, halfword(in_value, cur_idx), in_rd};
                    out_last_d  = (rem_mask == 4'b0000);
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_instr_d = '0;
                    end else begin
                        mask_d      = rem_mask;
                        out_instr_d = {MOVK_OPC, cur_idx, halfword(value_q, cur_idx), rd_q};
                        out_last_d  = (rem_mask == 4'b0000);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and registered outputs; reset drops any sequence in flight.
    always_ff @(posedge CLK) begin
        if (!resetl) begin
            state_q     <= IDLE;
            value_q     <= '0;
            rd_q        <= '0;
            mask_q      <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            value_q     <= value_d;
            rd_q        <= rd_d;
            mask_q      <= mask_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_movz_movk_sequencer.sv
// Directed testbench for movz_movk_sequencer with hand-computed encodings.
module tb_movz_movk_sequencer;

    logic        CLK = 1'b0;
    logic        resetl;
    logic        in_valid, in_valid0;
    logic [63:0] in_value;
    logic [4:0]  in_rd;
    logic        out_ready, out_ready0;

    logic        in_ready, out_valid, out_last;
    logic [31:0] out_instr;
    logic        in_ready0, out_valid0, out_last0;
    logic [31:0] out_instr0;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    movz_movk_sequencer dut (
        .CLK(CLK), .resetl(resetl),
        .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_last(out_last)
    );

    movz_movk_sequencer #(.SKIP_ZERO(1'b0)) dut0 (
        .CLK(CLK), .resetl(resetl),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_value(in_value), .in_rd(in_rd),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_instr(out_instr0), .out_last(out_last0)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Check the presented instruction on the default instance, then transfer it.
    task automatic expect_instr(input string tag, input logic [31:0] instr, input logic last);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_instr"}, 64'(out_instr), 64'(instr));
        check({tag, "_last"},  64'(out_last),  64'(last));
        tick();
    endtask

    task automatic expect_instr0(input string tag, input logic [31:0] instr, input logic last);
        check({tag, "_valid"}, 64'(out_valid0), 64'd1);
        check({tag, "_instr"}, 64'(out_instr0), 64'(instr));
        check({tag, "_last"},  64'(out_last0),  64'(last));
        tick();
    endtask

    task automatic request(input string tag, input logic [63:0] v, input logic [4:0] rd);
        in_value = v;
        in_rd    = rd;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_idle_ready"}, 64'(in_ready),  64'd1);
    endtask

    initial begin
        resetl     = 1'b0;
        in_valid   = 1'b0;
        in_valid0  = 1'b0;
        in_value   = '0;
        in_rd      = '0;
        out_ready  = 1'b1;
        out_ready0 = 1'b1;
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last",  64'(out_last),  64'd0);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst0_in_ready", 64'(in_ready0), 64'd1);
        resetl = 1'b1;
        tick();
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // 1: zero constant -> single MOVZ hw0
        request("t1", 64'h0, 5'd3);
        expect_instr("t1_i0", 32'hD280_0003, 1'b1);
        expect_idle("t1");

        // 2: low halfword only
        request("t2", 64'h1234, 5'd1);
        expect_instr("t2_i0", 32'hD282_4681, 1'b1);
        expect_idle("t2");

        // 3: hw0 and hw2 set, hw1/hw3 skipped
        request("t3", 64'h0000_BEEF_0000_0001, 5'd0);
        expect_instr("t3_i0", 32'hD280_0020, 1'b0);
        expect_instr("t3_i1", 32'hF2D7_DDE0, 1'b1);
        expect_idle("t3");

        // 3b: same constant without zero skipping -> all four halfwords
        in_value  = 64'h0000_BEEF_0000_0001;
        in_rd     = 5'd0;
        in_valid0 = 1'b1;
        check("t3b_in_ready", 64'(in_ready0), 64'd1);
        tick();
        in_valid0 = 1'b0;
        expect_instr0("t3b_i0", 32'hD280_0020, 1'b0);
        expect_instr0("t3b_i1", 32'hF2A0_0000, 1'b0);
        expect_instr0("t3b_i2", 32'hF2D7_DDE0, 1'b0);
        expect_instr0("t3b_i3", 32'hF2E0_0000, 1'b1);
        check("t3b_idle_valid", 64'(out_valid0), 64'd0);
        check("t3b_idle_ready", 64'(in_ready0),  64'd1);

        // 4: top halfword only, rd=31
        request("t4", 64'hFFFF_0000_0000_0000, 5'd31);
        expect_instr("t4_i0", 32'hD2FF_FFFF, 1'b1);
        expect_idle("t4");

        // 5: backpressure after the second instruction is presented
        request("t5", 64'h0001_0001_0001_0001, 5'd2);
        expect_instr("t5_i0", 32'hD280_0022, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_bp_valid",    64'(out_valid), 64'd1);
            check("t5_bp_instr",    64'(out_instr), 64'hF2A0_0022);
            check("t5_bp_last",     64'(out_last),  64'd0);
            check("t5_bp_in_ready", 64'(in_ready),  64'd0);
        end
        out_ready = 1'b1;
        expect_instr("t5_i1", 32'hF2A0_0022, 1'b0);
        expect_instr("t5_i2", 32'hF2C0_0022, 1'b0);
        expect_instr("t5_i3", 32'hF2E0_0022, 1'b1);
        expect_idle("t5");

        // 6: reset mid-sequence, then a fresh request
        request("t6", 64'h0001_0001_0001_0001, 5'd2);
        expect_instr("t6_i0", 32'hD280_0022, 1'b0);
        resetl = 1'b0;
        tick();
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_instr", 64'(out_instr), 64'd0);
        check("t6_rst_last",  64'(out_last),  64'd0);
        resetl = 1'b1;
        check("t6_rel_ready", 64'(in_ready), 64'd1);
        request("t6b", 64'h1234, 5'd1);
        expect_instr("t6b_i0", 32'hD282_4681, 1'b1);
        expect_idle("t6b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
